// File: rtl/bridge_pkg.sv
// bridge_pkg: shared state encoding, AHB responses and APB slave selects for the AHB2APB bridge.
package bridge_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_WWAIT, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;
   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [2:0] INTERRUPT_CONTROLLER = 3'b001;
   localparam logic [2:0] COUNTER_TIMER        = 3'b010;
   localparam logic [2:0] REMAP_PAUSE          = 3'b100;
endpackage

// File: rtl/apb_master_controller.sv
// apb_master_controller: sequences one APB SETUP/ACCESS transfer per AHB transfer,
// stalling AHB via Hreadyout and returning read data or a two-cycle ERROR response.
module apb_master_controller
   import bridge_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              Hclk,
   input  logic              Hreset,
   input  logic              valid,
   input  logic [ADDR_W-1:0] Haddr,
   input  logic              Hwrite,
   input  logic [DATA_W-1:0] Hwdata,
   input  logic [2:0]        tempselx,
   input  logic [DATA_W-1:0] Prdata,
   input  logic              Pready,
   input  logic              Pslverr,
   output logic [ADDR_W-1:0] Paddr,
   output logic [DATA_W-1:0] Pwdata,
   output logic              Pwrite,
   output logic [2:0]        Pselx,
   output logic              Penable,
   output logic              Hreadyout,
   output logic [DATA_W-1:0] Hrdata,
   output logic [1:0]        Hresp
);
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

   state_t            state, next;
   logic [2:0]        sel_hold;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] rdata_q;
   logic              done, tmo, accept;

   assign done   = state == ST_ACCESS && Pready && !Pslverr;
   assign tmo    = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1) && !Pready;
   assign accept = valid && (state == ST_IDLE || done);

   always_ff @(posedge Hclk or posedge Hreset)
      if (Hreset) state <= ST_IDLE;
      else        state <= next;

   always_comb begin
      next = state;
      case (state)
         ST_IDLE:   next = valid ? (Hwrite ? ST_WWAIT : ST_SETUP) : ST_IDLE;
         ST_WWAIT:  next = ST_SETUP;
         ST_SETUP:  next = ST_ACCESS;
         ST_ACCESS: next = done ? (valid ? (Hwrite ? ST_WWAIT : ST_SETUP) : ST_IDLE)
                                : (Pready || tmo) ? ST_ERR1 : ST_ACCESS;
         ST_ERR1:   next = ST_ERR2;
         default:   next = ST_IDLE;
      endcase
   end

   // Read data is bypassed on the completion cycle so AHB sees it with Hreadyout.
   always_comb begin
      Hreadyout = state == ST_IDLE || state == ST_ERR2 || done;
      Hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
      Hrdata    = (done && !Pwrite) ? Prdata : rdata_q;
   end

   always_ff @(posedge Hclk or posedge Hreset)
      if (Hreset) begin
         Paddr    <= '0;
         Pwdata   <= '0;
         Pwrite   <= 1'b0;
         Pselx    <= '0;
         Penable  <= 1'b0;
         rdata_q  <= '0;
         sel_hold <= '0;
         cnt      <= '0;
      end else begin
         if (accept) begin
            Paddr    <= Haddr;
            Pwrite   <= Hwrite;
            sel_hold <= tempselx;
         end
         if (state == ST_WWAIT) Pwdata <= Hwdata;
         if (done && !Pwrite) rdata_q <= Prdata;
         // A read accepted this cycle goes straight to SETUP before sel_hold is loaded.
         Pselx   <= next == ST_SETUP ? (accept ? tempselx : sel_hold)
                  : next == ST_ACCESS ? Pselx : '0;
         Penable <= next == ST_ACCESS;
         cnt     <= state == ST_SETUP ? '0
                  : (state == ST_ACCESS && !Pready && cnt != CW'(TIMEOUT)) ? cnt + CW'(1) : cnt;
      end
endmodule

// File: tb/tb_apb_master_controller.sv
// tb_apb_master_controller: directed and randomized transfers checked against a
// transaction-level timeline model of the APB master.
module tb_apb_master_controller;
   import bridge_pkg::*;
   localparam int TMO = 4;

   logic        Hclk = 1'b0, Hreset, valid, Hwrite, Pready, Pslverr;
   logic [31:0] Haddr, Hwdata, Prdata, Paddr, Pwdata, Hrdata;
   logic [2:0]  tempselx, Pselx;
   logic        Pwrite, Penable, Hreadyout;
   logic [1:0]  Hresp;
   int          checks = 0, failures = 0;
   logic [31:0] last_rd = '0;
   logic [2:0]  sels [3] = '{INTERRUPT_CONTROLLER, COUNTER_TIMER, REMAP_PAUSE};

   always #5 Hclk = ~Hclk;

   apb_master_controller #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Haddr(Haddr), .Hwrite(Hwrite),
      .Hwdata(Hwdata), .tempselx(tempselx), .Prdata(Prdata), .Pready(Pready),
      .Pslverr(Pslverr), .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite), .Pselx(Pselx),
      .Penable(Penable), .Hreadyout(Hreadyout), .Hrdata(Hrdata), .Hresp(Hresp)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge Hclk);
      #1;
   endtask

   task automatic noise;
      valid    = 1'($urandom_range(0, 1));
      Hwrite   = 1'($urandom_range(0, 1));
      Haddr    = $urandom;
      tempselx = 3'b111;
   endtask

   // One transfer: address phase (unless already issued on the previous completion),
   // optional write data phase, SETUP, ACCESS cycles, then error or idle tail.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] sel, input int waits, input bit err,
                       input logic [31:0] rd, input bit pre, input bit chain,
                       input logic nw, input logic [31:0] na, input logic [2:0] nsel);
      bit to, last, ok;
      int nacc;
      to   = waits >= TMO;
      nacc = to ? TMO : waits + 1;
      ok   = 1'b0;
      if (!pre) begin
         valid = 1'b1; Hwrite = w; Haddr = a; tempselx = sel;
         @(negedge Hclk);
         chk("idle_ready", 32'(Hreadyout), 1);
         chk("idle_psel", 32'(Pselx), 0);
         tick;
      end
      noise;
      if (w) begin
         Hwdata = d;
         @(negedge Hclk);
         chk("wwait_ready", 32'(Hreadyout), 0);
         chk("wwait_psel", 32'(Pselx), 0);
         chk("wwait_pen", 32'(Penable), 0);
         tick;
         Hwdata = $urandom;
      end
      @(negedge Hclk);
      chk("setup_psel", 32'(Pselx), 32'(sel));
      chk("setup_pen", 32'(Penable), 0);
      chk("setup_ready", 32'(Hreadyout), 0);
      chk("setup_paddr", Paddr, a);
      chk("setup_pwrite", 32'(Pwrite), 32'(w));
      if (w) chk("setup_pwdata", Pwdata, d);
      tick;
      for (int i = 0; i < nacc; i++) begin
         last    = i == nacc - 1;
         ok      = last && !to && !err;
         Pready  = last && !to;
         Pslverr = Pready ? err : 1'($urandom_range(0, 1));
         Prdata  = last ? rd : $urandom;
         noise;
         if (ok) begin
            valid = chain; Hwrite = nw; Haddr = na; tempselx = nsel;
         end
         @(negedge Hclk);
         chk("acc_psel", 32'(Pselx), 32'(sel));
         chk("acc_pen", 32'(Penable), 1);
         chk("acc_paddr", Paddr, a);
         chk("acc_pwrite", 32'(Pwrite), 32'(w));
         chk("acc_ready", 32'(Hreadyout), 32'(ok));
         chk("acc_hrdata", Hrdata, (ok && !w) ? rd : last_rd);
         if (w) chk("acc_pwdata", Pwdata, d);
         if (!last || ok) chk("acc_resp", 32'(Hresp), 32'(HRESP_OKAY));
         tick;
      end
      if (ok && !w) last_rd = rd;
      Pready = 1'b0; Pslverr = 1'b0;
      if (!ok) begin
         noise;
         @(negedge Hclk);
         chk("err1_resp", 32'(Hresp), 32'(HRESP_ERROR));
         chk("err1_ready", 32'(Hreadyout), 0);
         chk("err1_psel", 32'(Pselx), 0);
         chk("err1_pen", 32'(Penable), 0);
         tick;
         valid = 1'b1; tempselx = sel;
         @(negedge Hclk);
         chk("err2_resp", 32'(Hresp), 32'(HRESP_ERROR));
         chk("err2_ready", 32'(Hreadyout), 1);
         chk("err2_psel", 32'(Pselx), 0);
         tick;
      end
      if (!(ok && chain)) begin
         valid = 1'b0;
         @(negedge Hclk);
         chk("tail_psel", 32'(Pselx), 0);
         chk("tail_pen", 32'(Penable), 0);
         chk("tail_ready", 32'(Hreadyout), 1);
         chk("tail_resp", 32'(Hresp), 32'(HRESP_OKAY));
         chk("tail_hrdata", Hrdata, last_rd);
         tick;
      end
   endtask

   initial begin
      logic        cw, nw;
      logic [31:0] ca, cd, crd, na;
      logic [2:0]  csel, nsel;
      int          cwait;
      bit          cerr, pre, chain;
      Hreset = 1'b0; valid = 1'b0; Hwrite = 1'b0; Haddr = '0; Hwdata = '0;
      tempselx = '0; Prdata = '0; Pready = 1'b0; Pslverr = 1'b0;
      #1 Hreset = 1'b1;
      tick;
      @(negedge Hclk);
      chk("rst_paddr", Paddr, 0);
      chk("rst_pwdata", Pwdata, 0);
      chk("rst_pwrite", 32'(Pwrite), 0);
      chk("rst_psel", 32'(Pselx), 0);
      chk("rst_pen", 32'(Penable), 0);
      chk("rst_hrdata", Hrdata, 0);
      chk("rst_ready", 32'(Hreadyout), 1);
      chk("rst_resp", 32'(Hresp), 32'(HRESP_OKAY));
      tick;
      Hreset = 1'b0;
      tick;
      xfer(1'b0, 32'h8000_0010, 32'h0, INTERRUPT_CONTROLLER, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
      xfer(1'b1, 32'h8400_0004, 32'h1234_5678, COUNTER_TIMER, 3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
      xfer(1'b1, 32'h8800_0000, 32'hCAFE_F00D, REMAP_PAUSE, 1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8000_0020, INTERRUPT_CONTROLLER);
      xfer(1'b0, 32'h8000_0020, 32'h0, INTERRUPT_CONTROLLER, 0, 1'b0, 32'hA5A5_0F0F, 1'b1, 1'b0, 1'b0, 32'h0, 3'b000);
      xfer(1'b0, 32'h8400_0008, 32'h0, COUNTER_TIMER, 0, 1'b1, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
      xfer(1'b1, 32'h8800_000C, 32'h5555_AAAA, REMAP_PAUSE, TMO, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
      valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8800_0010; tempselx = REMAP_PAUSE; Pready = 1'b0;
      tick;
      valid = 1'b0;
      tick;
      @(negedge Hclk);
      chk("pre_rst_pen", 32'(Penable), 1);
      #2 Hreset = 1'b1;
      #1;
      chk("async_rst_psel", 32'(Pselx), 0);
      chk("async_rst_pen", 32'(Penable), 0);
      chk("async_rst_ready", 32'(Hreadyout), 1);
      chk("async_rst_resp", 32'(Hresp), 32'(HRESP_OKAY));
      chk("async_rst_hrdata", Hrdata, 0);
      last_rd = '0;
      tick;
      Hreset = 1'b0;
      tick;
      pre = 1'b0; cw = 1'b0; ca = '0; csel = '0;
      for (int i = 0; i < 40; i++) begin
         if (!pre) begin
            cw = 1'($urandom_range(0, 1)); ca = $urandom; csel = sels[$urandom_range(0, 2)];
         end
         cd    = $urandom;
         crd   = $urandom;
         cwait = $urandom_range(0, 5);
         cerr  = $urandom_range(0, 5) == 0;
         nw    = 1'($urandom_range(0, 1));
         na    = $urandom;
         nsel  = sels[$urandom_range(0, 2)];
         chain = !cerr && cwait < TMO && i != 39 && $urandom_range(0, 1) == 1;
         xfer(cw, ca, cd, csel, cwait, cerr, crd, pre, chain, nw, na, nsel);
         pre = chain;
         if (chain) begin
            cw = nw; ca = na; csel = nsel;
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
